instruction_sequencer: RTL



---
 rtl/instruction_sequencer_if.sv | 27 ++
 rtl/instruction_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer_if.sv
// instruction_sequencer_if
//   Handshake and shared-bus bundle between the instruction sequencer and
//   its instruction sub-state machines.
//   phase_start : one-hot start, driven by the sequencer
//   phase_done  : per-phase done, driven by the sub-machines
//   instruction : shared instruction bus, driven by the started sub-machine
//   Modports: master = sequencer side, slave = sub-machine side.
interface instruction_sequencer_if #(
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned INSTR_W    = 21
);
    logic [NUM_PHASES-1:0] phase_start;
    logic [NUM_PHASES-1:0] phase_done;
    logic [INSTR_W-1:0]    instruction;

    modport master (
        output phase_start,
        input  phase_done,
        input  instruction
    );

    modport slave (
        input  phase_start,
        output phase_done,
        output instruction
    );
endinterface

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Steps the instruction sub-machines in order 0..NUM_PHASES-1 by raising one
//   one-hot start line at a time, registers the instruction the started
//   sub-machine drives onto the shared bus, counts completed iterations and
//   traps a phase that holds start too long without done.
// Ports:
//   clk_i, reset_n_i     : clock, asynchronous active-low reset
//   run_i                : level, enables sequencing
//   halt_i               : stop request, honoured only at last-phase done
//   clear_fault_i        : leaves FAULT back to IDLE
//   sub_if (master)      : phase_start / phase_done / instruction bus
//   instruction_o        : instruction registered from the bus
//   instruction_valid_o  : instruction_o holds a value sampled in RUN
//   phase_o              : current phase index
//   iteration_count_o    : completed full iterations (wraps)
//   busy_o, fault_o      : RUN / FAULT state indicators
module instruction_sequencer #(
    parameter int unsigned NUM_PHASES     = 4,
    parameter int unsigned INSTR_W        = 21,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ITER_W         = 32,
    localparam int unsigned PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  run_i,
    input  logic                  halt_i,
    input  logic                  clear_fault_i,
    instruction_sequencer_if.master sub_if,
    output logic [INSTR_W-1:0]    instruction_o,
    output logic                  instruction_valid_o,
    output logic [PH_W-1:0]       phase_o,
    output logic [ITER_W-1:0]     iteration_count_o,
    output logic                  busy_o,
    output logic                  fault_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [INSTR_W-1:0]  instr_q;
    logic                valid_q;
    logic [NUM_PHASES-1:0] start;
    logic                cur_done;
    logic                last_phase;
    logic                timeout;

    // Only the done bit of the active phase is honoured; others are ignored.
    assign cur_done   = (state_q == S_RUN) && sub_if.phase_done[phase_q];
    assign last_phase = (phase_q == PH_W'(NUM_PHASES - 1));
    assign timeout    = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, phase, watchdog and iteration logic
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        wd_d    = wd_q;
        iter_d  = iter_q;
        unique case (state_q)
            S_IDLE: begin
                if (run_i && !halt_i) begin
                    state_d = S_RUN;
                    phase_d = '0;
                    wd_d    = '0;
                end
            end
            S_RUN: begin
                // Done on the final allowed cycle takes priority over timeout.
                if (cur_done) begin
                    wd_d = '0;
                    if (last_phase) begin
                        iter_d  = iter_q + 1'b1;
                        phase_d = '0;
                        if (halt_i || !run_i) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end else if (timeout) begin
                    state_d = S_FAULT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_FAULT: begin
                if (clear_fault_i) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                    wd_d    = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
                wd_d    = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            phase_q <= '0;
            wd_q    <= '0;
            iter_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            wd_q    <= wd_d;
            iter_q  <= iter_d;
            valid_q <= (state_q == S_RUN);
            if (state_q == S_RUN) begin
                instr_q <= sub_if.instruction;
            end
        end
    end

    // One-hot start decoded from the registered phase, low outside RUN so
    // the bus is released immediately on reset or fault.
    always_comb begin
        start = '0;
        if (state_q == S_RUN) begin
            for (int unsigned i = 0; i < NUM_PHASES; i++) begin
                start[i] = (phase_q == PH_W'(i));
            end
        end
    end

    assign sub_if.phase_start  = start;
    assign instruction_o       = instr_q;
    assign instruction_valid_o = valid_q;
    assign phase_o             = phase_q;
    assign iteration_count_o   = iter_q;
    assign busy_o              = (state_q == S_RUN);
    assign fault_o             = (state_q == S_FAULT);

endmodule
